approx_err_monitor: RTL and testbench

- Sits directly downstream of the 8x8 recursive approximate multipliers (exact/approximate 4x4 sub-products combined into a 16-bit product).
- Consumes a stream of (a, b, y_approx) samples and recomputes the exact product a*b internally.
- Accumulates the error metrics the team reports per configuration: sum of error distance (for MED), max error distance, erroneous-sample count (for ER), sample count.
- Run of N samples is started by a pulse. Results are held after completion until the next start.

---
 rtl/approx_err_monitor_pkg.sv | 25 ++
 rtl/approx_err_monitor_if.sv | 15 +
 rtl/approx_err_monitor_err_dist_stage.sv | 68 ++++++
 rtl/approx_err_monitor.sv | 163 ++++++++++++++++
 tb/tb_approx_err_monitor.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_err_monitor_pkg.sv
// rtl/approx_err_monitor_pkg.sv - shared widths, FSM states and saturating add for approx_err_monitor
package approx_mult_pkg;

  localparam int OP_W_DEF   = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int CNT_W_DEF  = 24;
  localparam int PROD_W_DEF = 2 * OP_W_DEF;

  // Widest accumulator handled by sat_add; sum_sq_ed needs 2*ACC_W <= SAT_W.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mon_state_e;

  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] acc,
                                               input logic [SAT_W-1:0] inc,
                                               input logic [SAT_W-1:0] lim);
    logic [SAT_W:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    if (sum > {1'b0, lim}) begin
      return lim;
    end
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/approx_err_monitor_if.sv
// rtl/approx_err_monitor_if.sv - sample stream (a, b, y_approx) with valid/ready handshake
interface approx_err_monitor_if
  import approx_mult_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic [2*OP_W-1:0] y_approx;

  modport master (output in_valid, a, b, y_approx, input in_ready);
  modport slave  (input in_valid, a, b, y_approx, output in_ready);
endinterface

// File: rtl/approx_err_monitor_err_dist_stage.sv
// rtl/approx_err_monitor_err_dist_stage.sv - S1 exact product / S2 absolute error distance pipeline
module err_dist_stage
  import approx_mult_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_fire,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [2*OP_W-1:0] y_approx,
  output logic              s1_valid,
  output logic              s2_valid,
  output logic [2*OP_W-1:0] ed,
  output logic              ed_nz
);
  localparam int PW = 2 * OP_W;

  logic          s1_valid_q, s1_valid_d;
  logic          s2_valid_q, s2_valid_d;
  logic [PW-1:0] exact_q, exact_d;
  logic [PW-1:0] y_q, y_d;
  logic [PW-1:0] ed_q, ed_d;
  logic          ed_nz_q, ed_nz_d;

  always_comb begin
    s1_valid_d = in_fire;
    exact_d    = exact_q;
    y_d        = y_q;
    s2_valid_d = s1_valid_q;
    ed_d       = ed_q;
    ed_nz_d    = ed_nz_q;
    if (in_fire) begin
      exact_d = PW'(a) * PW'(b);
      y_d     = y_approx;
    end
    // Distance is taken in the direction that cannot underflow.
    if (s1_valid_q) begin
      ed_d    = (exact_q >= y_q) ? (exact_q - y_q) : (y_q - exact_q);
      ed_nz_d = (exact_q != y_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      exact_q    <= '0;
      y_q        <= '0;
      ed_q       <= '0;
      ed_nz_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      exact_q    <= exact_d;
      y_q        <= y_d;
      ed_q       <= ed_d;
      ed_nz_q    <= ed_nz_d;
    end
  end

  assign s1_valid = s1_valid_q;
  assign s2_valid = s2_valid_q;
  assign ed       = ed_q;
  assign ed_nz    = ed_nz_q;

endmodule

// File: rtl/approx_err_monitor.sv
// rtl/approx_err_monitor.sv - run-based error metrics for approximate multipliers; APPROX_ERR_MON_SQ_EN adds sum_sq_ed
module approx_err_monitor
  import approx_mult_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     n_samples,
  approx_err_monitor_if.slave  s_if,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_W-1:0]     sum_ed,
  output logic [2*OP_W-1:0]    max_ed,
  output logic [ACC_W-1:0]     err_cnt,
  output logic [ACC_W-1:0]     sample_cnt
`ifdef APPROX_ERR_MON_SQ_EN
  ,
  output logic [2*ACC_W-1:0]   sum_sq_ed
`endif
);
  localparam int PW = 2 * OP_W;
  localparam logic [SAT_W-1:0] ACC_MAX = SAT_W'({ACC_W{1'b1}});

  mon_state_e     state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] accepted_q, accepted_d;
  logic             done_q, done_d;
  logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
  logic [PW-1:0]    max_ed_q, max_ed_d;
  logic [ACC_W-1:0] err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0] sample_cnt_q, sample_cnt_d;

  logic          in_ready;
  logic          fire;
  logic          s1_valid, s2_valid;
  logic [PW-1:0] ed;
  logic          ed_nz;

  assign in_ready      = (state_q == RUN) && (accepted_q < target_q);
  assign fire          = s_if.in_valid && in_ready;
  assign s_if.in_ready = in_ready;

  err_dist_stage #(.OP_W(OP_W)) u_err_dist (
    .clk      (clk),
    .rst      (rst),
    .in_fire  (fire),
    .a        (s_if.a),
    .b        (s_if.b),
    .y_approx (s_if.y_approx),
    .s1_valid (s1_valid),
    .s2_valid (s2_valid),
    .ed       (ed),
    .ed_nz    (ed_nz)
  );

`ifdef APPROX_ERR_MON_SQ_EN
  localparam int SQ_W = 2 * PW;
  localparam logic [SAT_W-1:0] SQ_MAX = SAT_W'({(2*ACC_W){1'b1}});
  logic [SQ_W-1:0]    ed_sq;
  logic [2*ACC_W-1:0] sum_sq_q, sum_sq_d;
  assign ed_sq = SQ_W'(ed) * SQ_W'(ed);
`endif

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    accepted_d   = accepted_q;
    done_d       = 1'b0;
    sum_ed_d     = sum_ed_q;
    max_ed_d     = max_ed_q;
    err_cnt_d    = err_cnt_q;
    sample_cnt_d = sample_cnt_q;
`ifdef APPROX_ERR_MON_SQ_EN
    sum_sq_d     = sum_sq_q;
`endif

    if (s2_valid) begin
      sum_ed_d     = ACC_W'(sat_add(SAT_W'(sum_ed_q), SAT_W'(ed), ACC_MAX));
      max_ed_d     = (ed > max_ed_q) ? ed : max_ed_q;
      err_cnt_d    = ACC_W'(sat_add(SAT_W'(err_cnt_q), SAT_W'(ed_nz), ACC_MAX));
      sample_cnt_d = ACC_W'(sat_add(SAT_W'(sample_cnt_q), SAT_W'(1), ACC_MAX));
`ifdef APPROX_ERR_MON_SQ_EN
      sum_sq_d     = (2*ACC_W)'(sat_add(SAT_W'(sum_sq_q), SAT_W'(ed_sq), SQ_MAX));
`endif
    end

    case (state_q)
      IDLE, DONE: begin
        // Pipeline is always empty here, so clearing cannot drop a sample.
        if (start) begin
          target_d     = n_samples;
          accepted_d   = '0;
          sum_ed_d     = '0;
          max_ed_d     = '0;
          err_cnt_d    = '0;
          sample_cnt_d = '0;
`ifdef APPROX_ERR_MON_SQ_EN
          sum_sq_d     = '0;
`endif
          state_d      = (n_samples == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (fire) begin
          accepted_d = accepted_q + CNT_W'(1);
        end
        if (accepted_d == target_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid && !s2_valid) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      target_q     <= '0;
      accepted_q   <= '0;
      done_q       <= 1'b0;
      sum_ed_q     <= '0;
      max_ed_q     <= '0;
      err_cnt_q    <= '0;
      sample_cnt_q <= '0;
`ifdef APPROX_ERR_MON_SQ_EN
      sum_sq_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      accepted_q   <= accepted_d;
      done_q       <= done_d;
      sum_ed_q     <= sum_ed_d;
      max_ed_q     <= max_ed_d;
      err_cnt_q    <= err_cnt_d;
      sample_cnt_q <= sample_cnt_d;
`ifdef APPROX_ERR_MON_SQ_EN
      sum_sq_q     <= sum_sq_d;
`endif
    end
  end

  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = done_q;
  assign sum_ed     = sum_ed_q;
  assign max_ed     = max_ed_q;
  assign err_cnt    = err_cnt_q;
  assign sample_cnt = sample_cnt_q;
`ifdef APPROX_ERR_MON_SQ_EN
  assign sum_sq_ed  = sum_sq_q;
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// tb/tb_approx_err_monitor.sv - self-checking bench for approx_err_monitor (honours APPROX_ERR_MON_SQ_EN)
module tb_approx_err_monitor;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        start;
  logic [23:0] n_samples;
  logic        busy, done;
  logic [31:0] sum_ed, err_cnt, sample_cnt;
  logic [15:0] max_ed;
`ifdef APPROX_ERR_MON_SQ_EN
  logic [63:0] sum_sq_ed;
`endif

  logic        s_start;
  logic [23:0] s_n;
  logic        s_busy, s_done;
  logic [7:0]  s_sum, s_err, s_cnt;
  logic [15:0] s_max;
`ifdef APPROX_ERR_MON_SQ_EN
  logic [15:0] s_sq;
`endif

  approx_err_monitor_if #(.OP_W(8)) m_if ();
  approx_err_monitor_if #(.OP_W(8)) s_if2 ();

  approx_err_monitor #(.OP_W(8), .ACC_W(32), .CNT_W(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_samples  (n_samples),
    .s_if       (m_if),
    .busy       (busy),
    .done       (done),
    .sum_ed     (sum_ed),
    .max_ed     (max_ed),
    .err_cnt    (err_cnt),
    .sample_cnt (sample_cnt)
`ifdef APPROX_ERR_MON_SQ_EN
    ,
    .sum_sq_ed  (sum_sq_ed)
`endif
  );

  approx_err_monitor #(.OP_W(8), .ACC_W(8), .CNT_W(24)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .start      (s_start),
    .n_samples  (s_n),
    .s_if       (s_if2),
    .busy       (s_busy),
    .done       (s_done),
    .sum_ed     (s_sum),
    .max_ed     (s_max),
    .err_cnt    (s_err),
    .sample_cnt (s_cnt)
`ifdef APPROX_ERR_MON_SQ_EN
    ,
    .sum_sq_ed  (s_sq)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;
  bit cmp_en  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=idle 1=run 2=drain 3=done; queue holds samples
  // transferred but not yet accumulated, each due two edges after its transfer.
  localparam longint ACC_LIM = 64'hFFFF_FFFF;
  int        m_phase = 0;
  longint    m_target = 0, m_acc = 0, cyc = 0;
  longint    m_sum = 0, m_max = 0, m_err = 0, m_cnt = 0;
  logic [64:0] m_sq = '0;
  longint    q_ed[$];
  longint    q_due[$];
  bit        m_done = 0, m_ready = 0, m_busy = 0;
  bit        xfer, empty_before;
  longint    e, ex, yy;

  function automatic longint sat(input longint v);
    return (v > ACC_LIM) ? ACC_LIM : v;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_phase = 0; m_target = 0; m_acc = 0;
      m_sum = 0; m_max = 0; m_err = 0; m_cnt = 0; m_sq = '0;
      q_ed.delete(); q_due.delete();
      m_done = 0;
    end else begin
      xfer = m_if.in_valid && m_ready;
      empty_before = (q_ed.size() == 0);
      m_done = 0;
      while (q_due.size() > 0 && q_due[0] == cyc) begin
        e = q_ed.pop_front();
        void'(q_due.pop_front());
        m_sum = sat(m_sum + e);
        if (e > m_max) m_max = e;
        if (e != 0) m_err = sat(m_err + 1);
        m_cnt = sat(m_cnt + 1);
        m_sq = m_sq + 65'(e * e);
        if (m_sq > 65'(64'hFFFF_FFFF_FFFF_FFFF)) m_sq = 65'(64'hFFFF_FFFF_FFFF_FFFF);
      end
      if (xfer) begin
        ex = longint'(m_if.a) * longint'(m_if.b);
        yy = longint'(m_if.y_approx);
        q_ed.push_back((ex >= yy) ? ex - yy : yy - ex);
        q_due.push_back(cyc + 2);
        m_acc++;
      end
      case (m_phase)
        0, 3: if (start) begin
          m_sum = 0; m_max = 0; m_err = 0; m_cnt = 0; m_sq = '0;
          m_target = longint'(n_samples);
          m_acc = 0;
          m_phase = (n_samples == 0) ? 2 : 1;
        end
        1: if (m_acc == m_target) m_phase = 2;
        2: if (empty_before) begin m_phase = 3; m_done = 1; end
        default: ;
      endcase
    end
    m_ready = (m_phase == 1) && (m_acc < m_target);
    m_busy  = (m_phase == 1) || (m_phase == 2);
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("in_ready", 64'(m_if.in_ready), 64'(m_ready));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("sum_ed", 64'(sum_ed), m_sum);
      chk("max_ed", 64'(max_ed), m_max);
      chk("err_cnt", 64'(err_cnt), m_err);
      chk("sample_cnt", 64'(sample_cnt), m_cnt);
`ifdef APPROX_ERR_MON_SQ_EN
      chk("sum_sq_ed", sum_sq_ed, m_sq[63:0]);
`endif
      if (done === 1'b1) done_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    n_samples = 24'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [15:0] y, input bit v);
    m_if.in_valid = v;
    m_if.a = a;
    m_if.b = b;
    m_if.y_approx = y;
    tick();
    m_if.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int i;
    i = 0;
    while (done !== 1'b1 && i < 500) begin
      tick();
      i++;
    end
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: done not seen within 500 cycles", nm);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_samples = '0;
    m_if.in_valid = 1'b0; m_if.a = '0; m_if.b = '0; m_if.y_approx = '0;
    s_start = 1'b0; s_n = '0;
    s_if2.in_valid = 1'b0; s_if2.a = '0; s_if2.b = '0; s_if2.y_approx = '0;
    tick();
    cmp_en = 1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ready", 64'(m_if.in_ready), 0);
    chk("rst_sample_cnt", 64'(sample_cnt), 0);
    tick();

    // exact products
    do_start(3);
    drive(8'd255, 8'd255, 16'd65025, 1);
    drive(8'd0, 8'd7, 16'd0, 1);
    drive(8'd15, 8'd15, 16'd225, 1);
    wait_done("exact");
    chk("exact_sum", 64'(sum_ed), 0);
    chk("exact_max", 64'(max_ed), 0);
    chk("exact_err", 64'(err_cnt), 0);
    chk("exact_cnt", 64'(sample_cnt), 3);

    // distance in both directions: 65025-65000=25, 12-9=3
    do_start(2);
    drive(8'd255, 8'd255, 16'd65000, 1);
    drive(8'd3, 8'd3, 16'd12, 1);
    wait_done("dist");
    chk("dist_sum", 64'(sum_ed), 28);
    chk("dist_max", 64'(max_ed), 25);
    chk("dist_err", 64'(err_cnt), 2);

    // gaps plus one extra valid after the last accepted sample
    done_seen = 0;
    do_start(4);
    drive(8'd10, 8'd10, 16'd90, 1);
    drive(8'd0, 8'd0, 16'd0, 0);
    drive(8'd2, 8'd3, 16'd6, 1);
    drive(8'd0, 8'd0, 16'd0, 0);
    drive(8'd200, 8'd100, 16'd20000, 1);
    drive(8'd0, 8'd0, 16'd0, 0);
    drive(8'd7, 8'd8, 16'd60, 1);
    drive(8'd0, 8'd0, 16'd0, 0);
    drive(8'd9, 8'd9, 16'd0, 1);
    wait_done("gaps");
    repeat (3) tick();
    chk("gaps_cnt", 64'(sample_cnt), 4);
    chk("gaps_sum", 64'(sum_ed), 14);
    chk("gaps_max", 64'(max_ed), 10);
    chk("gaps_err", 64'(err_cnt), 2);
    chk("gaps_ready", 64'(m_if.in_ready), 0);
    chk("gaps_done_once", 64'(done_seen), 1);

    // zero-length run
    done_seen = 0;
    do_start(0);
    wait_done("zero");
    chk("zero_cnt", 64'(sample_cnt), 0);
    chk("zero_sum", 64'(sum_ed), 0);
    chk("zero_done_once", 64'(done_seen), 1);

    // start during RUN must not clear or retarget
    do_start(3);
    drive(8'd1, 8'd2, 16'd2, 1);
    start = 1'b1; n_samples = 24'd10;
    drive(8'd0, 8'd0, 16'd0, 0);
    start = 1'b0;
    drive(8'd5, 8'd5, 16'd25, 1);
    drive(8'd6, 8'd6, 16'd30, 1);
    wait_done("restart");
    chk("restart_cnt", 64'(sample_cnt), 3);
    chk("restart_sum", 64'(sum_ed), 6);
    chk("restart_ready", 64'(m_if.in_ready), 0);

    // reset after 2 of 5 samples
    do_start(5);
    drive(8'd2, 8'd2, 16'd5, 1);
    drive(8'd3, 8'd3, 16'd1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_busy", 64'(busy), 0);
    chk("rstmid_cnt", 64'(sample_cnt), 0);
    chk("rstmid_sum", 64'(sum_ed), 0);
    repeat (3) tick();
    chk("rstmid_idle", 64'(sample_cnt), 0);
    do_start(1);
    drive(8'd4, 8'd4, 16'd15, 1);
    wait_done("after_rst");
    chk("after_rst_cnt", 64'(sample_cnt), 1);
    chk("after_rst_sum", 64'(sum_ed), 1);

    // ed = 256 for the squared-error check
    do_start(1);
    drive(8'd16, 8'd16, 16'd0, 1);
    wait_done("sq");
    chk("sq_sum", 64'(sum_ed), 256);
    chk("sq_max", 64'(max_ed), 256);
`ifdef APPROX_ERR_MON_SQ_EN
    chk("sq_sum_sq", sum_sq_ed, 65536);
`endif

    // saturation on the 8-bit accumulator instance
    s_start = 1'b1; s_n = 24'd300;
    tick();
    s_start = 1'b0;
    s_if2.in_valid = 1'b1; s_if2.a = 8'd1; s_if2.b = 8'd1; s_if2.y_approx = 16'd0;
    repeat (300) tick();
    s_if2.in_valid = 1'b0;
    begin
      int i;
      i = 0;
      while (s_done !== 1'b1 && i < 50) begin
        tick();
        i++;
      end
      n_tests++;
      if (s_done !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_done: done not seen within 50 cycles");
      end
    end
    tick();
    chk("sat_err", 64'(s_err), 255);
    chk("sat_cnt", 64'(s_cnt), 255);
    chk("sat_sum", 64'(s_sum), 255);
    chk("sat_max", 64'(s_max), 1);
    chk("sat_busy", 64'(s_busy), 0);
`ifdef APPROX_ERR_MON_SQ_EN
    chk("sat_sq", 64'(s_sq), 300);
`endif

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
